ring_johnson_seq: RTL and testbench

//  Parametrised timing-sequence generator: a WIDTH-bit rotating register, run-time selectable as
//  one-hot ring (WIDTH phases) or Johnson/twisted-ring (2*WIDTH phases), rotating in either direction.

---
 rtl/ring_johnson_seq.sv | 142 ++++++++++++++
 tb/tb_ring_johnson_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ring_johnson_seq.sv
// Rotating timing-sequence generator: one-hot ring (WIDTH phases) or Johnson (2*WIDTH phases),
// with decoded phase strobes, phase index, wrap pulse, parallel load and illegal-state recovery.
module ring_johnson_seq #(
  parameter int unsigned WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            mode,
  input  logic                            dir,
  input  logic                            load,
  input  logic [WIDTH-1:0]                load_val,
  output logic [WIDTH-1:0]                state,
  output logic [2*WIDTH-1:0]              phase,
  output logic [$clog2(2*WIDTH)-1:0]      phase_idx,
  output logic                            valid,
  output logic                            wrap,
  output logic                            err
);

  localparam int unsigned N2 = 2 * WIDTH;
  localparam int unsigned IW = $clog2(N2);
  localparam int unsigned CW = IW + 1;
  localparam logic [WIDTH-1:0] RING_RST = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] JOHN_RST = '0;

  logic [WIDTH-1:0] state_q, state_d;
  logic             mode_q,  mode_d;
  logic             wrap_q,  wrap_d;
  logic             err_q,   err_d;

  logic             valid_c;
  logic [IW-1:0]    idx_c;
  logic [N2-1:0]    phase_c;
  logic [IW-1:0]    last_idx_c;

  function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Legal Johnson patterns have at most one boundary between adjacent differing bits.
  function automatic logic johnson_ok(input logic [WIDTH-1:0] v);
    logic [CW-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      t = t + CW'(v[i] ^ v[i+1]);
    end
    return (t <= CW'(1));
  endfunction

  function automatic logic [IW-1:0] ring_index(input logic [WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IW'(WIDTH - 1 - i);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] johnson_index(input logic [WIDTH-1:0] v);
    logic [CW-1:0] pc;
    logic [IW-1:0] r;
    pc = popcnt(v);
    if (v == '0)           r = '0;
    else if (v[WIDTH-1])   r = IW'(pc);
    else                   r = IW'(CW'(N2) - pc);
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RING_RST;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Phase decode from the registered state and mode
  always_comb begin
    valid_c    = 1'b0;
    idx_c      = '0;
    phase_c    = '0;
    last_idx_c = mode_q ? IW'(N2 - 1) : IW'(WIDTH - 1);
    if (mode_q) begin
      valid_c = johnson_ok(state_q);
      if (valid_c) idx_c = johnson_index(state_q);
    end else begin
      valid_c = (popcnt(state_q) == CW'(1));
      if (valid_c) idx_c = ring_index(state_q);
    end
    for (int unsigned k = 0; k < N2; k++) begin
      phase_c[k] = valid_c && (idx_c == IW'(k));
    end
  end

  // Next state: load > mode change > correction > shift > hold
  always_comb begin
    state_d = state_q;
    mode_d  = mode;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      state_d = load_val;
    end else if (mode != mode_q) begin
      state_d = mode ? JOHN_RST : RING_RST;
    end else if (en && !valid_c) begin
      state_d = mode_q ? JOHN_RST : RING_RST;
      err_d   = 1'b1;
    end else if (en) begin
      case ({mode_q, dir})
        2'b00:   state_d = {state_q[0], state_q[WIDTH-1:1]};
        2'b01:   state_d = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
        2'b10:   state_d = {~state_q[0], state_q[WIDTH-1:1]};
        default: state_d = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
      endcase
      wrap_d = dir ? (idx_c == '0) : (idx_c == last_idx_c);
    end
  end

  // Output drive
  always_comb begin
    state     = state_q;
    wrap      = wrap_q;
    err       = err_q;
    valid     = valid_c;
    phase_idx = idx_c;
    phase     = phase_c;
  end

endmodule

// File: tb/tb_ring_johnson_seq.sv
// Directed bench for ring_johnson_seq (WIDTH=6): ring/Johnson stepping, wrap, load,
// illegal-state correction, hold, async reset and mode switching.
module tb_ring_johnson_seq;

  localparam int unsigned W  = 6;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          reset;
  logic          en;
  logic          mode;
  logic          dir;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  state;
  logic [2*W-1:0] phase;
  logic [IW-1:0] phase_idx;
  logic          valid;
  logic          wrap;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  ring_johnson_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .state     (state),
    .phase     (phase),
    .phase_idx (phase_idx),
    .valid     (valid),
    .wrap      (wrap),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] st, input int idx,
                            input logic vld, input logic wr, input logic er);
    logic [2*W-1:0] ph;
    ph = vld ? ((2*W)'(1) << idx) : '0;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".idx"},   32'(phase_idx), 32'(vld ? idx : 0));
    check({tag, ".valid"}, 32'(valid), 32'(vld));
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".wrap"},  32'(wrap), 32'(wr));
    check({tag, ".err"},   32'(err), 32'(er));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] john_seq [12] = '{6'b100000, 6'b110000, 6'b111000, 6'b111100,
                                  6'b111110, 6'b111111, 6'b011111, 6'b001111,
                                  6'b000111, 6'b000011, 6'b000001, 6'b000000};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    #12;
    expect_out("reset", 6'b100000, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Ring, rotate right
    en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      expect_out($sformatf("ring_r%0d", i), 6'b100000 >> (i % 6), i % 6, 1'b1, i == 6, 1'b0);
    end

    // Switch to Johnson, then run a full cycle right
    mode = 1'b1;
    step();
    expect_out("j_modechg", 6'b000000, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      expect_out($sformatf("john_r%0d", i), john_seq[i], (i + 1) % 12, 1'b1, i == 11, 1'b0);
    end

    // Back to ring, rotate left across the wrap
    mode = 1'b0;
    step();
    expect_out("r_modechg", 6'b100000, 0, 1'b1, 1'b0, 1'b0);
    dir = 1'b1;
    step();
    expect_out("ring_l0", 6'b000001, 5, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("ring_l1", 6'b000010, 4, 1'b1, 1'b0, 1'b0);

    // Illegal load, hold, then correction
    en = 1'b0; load = 1'b1; load_val = 6'b100100;
    step();
    expect_out("bad_load", 6'b100100, 0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    step();
    expect_out("bad_hold", 6'b100100, 0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    expect_out("bad_fix", 6'b100000, 0, 1'b1, 1'b0, 1'b1);
    step();
    expect_out("after_fix", 6'b000001, 5, 1'b1, 1'b1, 1'b0);

    // Hold for 5 edges, then async reset mid-cycle
    en = 1'b0; load = 1'b1; load_val = 6'b001000;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("hold%0d", i), 6'b001000, 2, 1'b1, 1'b0, 1'b0);
    end
    #1 reset = 1'b1;
    #1;
    expect_out("async_rst", 6'b100000, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; dir = 1'b0;
    step();
    expect_out("post_rst", 6'b010000, 1, 1'b1, 1'b0, 1'b0);

    // Load wins over a simultaneous mode change
    en = 1'b0; load = 1'b1; load_val = 6'b001000;
    step();
    mode = 1'b1; load_val = 6'b111000;
    step();
    expect_out("load_mode", 6'b111000, 3, 1'b1, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    step();
    expect_out("john_after", 6'b111100, 4, 1'b1, 1'b0, 1'b0);

    // Johnson left wrap from phase 0
    en = 1'b0; load = 1'b1; load_val = 6'b000000;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step();
    expect_out("john_lwrap", 6'b000001, 11, 1'b1, 1'b1, 1'b0);

    // Johnson illegal state corrected to all-zero
    en = 1'b0; load = 1'b1; load_val = 6'b101000;
    step();
    expect_out("jbad_load", 6'b101000, 0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    step();
    expect_out("jbad_fix", 6'b000000, 0, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
